// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package reg_file_mp_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // An address names a real, writable register: inside the file and not a hardwired x0.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned nregs,
                                   input logic zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == 32'(REG_ZERO)));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read / write / reserve bundle between the core pipeline (master) and the register file (slave).
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1
) ();

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits: set by a reservation, cleared by writeback, reservation wins a tie.
module reg_file_mp_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NWR-1:0]         clr_en,
  input  logic [NWR-1:0][AW-1:0] clr_addr,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  output logic [NRD-1:0]         rd_busy
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state: writebacks clear first, then a reservation sets (new producer wins).
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (clr_en[j] && addr_ok(32'(clr_addr[j]), NREGS, ZERO_EN)) begin
        busy_d[clr_addr[j]] = 1'b0;
      end
    end
    if (rsv_en && addr_ok(32'(rsv_addr), NREGS, ZERO_EN)) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Busy flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Busy lookup per read port; out-of-range and x0 read as not busy.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (addr_ok(32'(rd_addr[i]), NREGS, ZERO_EN)) begin
        rd_busy[i] = busy_q[rd_addr[i]];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional x0 hardwiring, write-to-read bypass and
// a busy scoreboard for in-flight producers.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NRD-1:0]  byp_hit;
  logic [NRD-1:0]  sb_busy;

  // Write next-state: ports applied in ascending order so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (bus.wr_en[j] && addr_ok(32'(bus.wr_addr[j]), NREGS, ZERO_EN)) begin
        regs_d[bus.wr_addr[j]] = bus.wr_data[j];
      end
    end
  end

  // Data array, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Combinational read with optional same-cycle forwarding of in-flight write data.
  always_comb begin
    byp_hit     = '0;
    bus.rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (addr_ok(32'(bus.rd_addr[i]), NREGS, ZERO_EN)) begin
        bus.rd_data[i] = regs_q[bus.rd_addr[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j] == bus.rd_addr[i])) begin
              bus.rd_data[i] = bus.wr_data[j];
              byp_hit[i]     = 1'b1;
            end
          end
        end
      end
      // Forwarding must not leak through while the file is held in reset.
      if (rst) begin
        bus.rd_data[i] = '0;
      end
    end
  end

  reg_file_mp_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .clr_en   (bus.wr_en),
    .clr_addr (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (sb_busy)
  );

  // A forwarded value is the finished producer, so the port is no longer busy.
  assign bus.rd_busy = rst ? '0 : (sb_busy & ~byp_hit);

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (32 regs with bypass, 24 regs without) share one
// random/directed stimulus stream and are checked against an array-based reference model.
module tb_reg_file_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;

  typedef struct {
    int          inst;
    int          port;
    int          cyc;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) bus_a ();
  reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) bus_b ();

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(24), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Stimulus variables, copied onto both buses each cycle.
  logic              rst_v;
  logic [AW-1:0]     rd_addr_v [NRD];
  logic              wr_en_v   [NWR];
  logic [AW-1:0]     wr_addr_v [NWR];
  logic [31:0]       wr_data_v [NWR];
  logic              rsv_en_v;
  logic [AW-1:0]     rsv_addr_v;

  // Reference model: plain arrays of register contents and pending-producer flags.
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];
  int unsigned m_nregs [2] = '{32, 24};
  bit          m_byp   [2] = '{1'b1, 1'b0};

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic bit m_real(int inst, logic [AW-1:0] a);
    int unsigned ai = 32'(a);
    return (ai < m_nregs[inst]) && (ai != 0);
  endfunction

  function automatic void m_read(input int inst, input logic [AW-1:0] a,
                                 output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (rst_v || !m_real(inst, a)) return;
    d = m_reg[inst][a];
    b = m_busy[inst][a];
    if (m_byp[inst]) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_v[j] && wr_addr_v[j] == a) begin
          d = wr_data_v[j];
          b = 1'b0;
        end
      end
    end
  endfunction

  task automatic idle();
    rst_v    = 1'b0;
    rsv_en_v = 1'b0;
    rsv_addr_v = '0;
    for (int i = 0; i < NRD; i++) rd_addr_v[i] = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_en_v[j]   = 1'b0;
      wr_addr_v[j] = '0;
      wr_data_v[j] = '0;
    end
  endtask

  // One cycle: drive inputs at the falling edge, queue expected reads, advance the model.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    rst = rst_v;
    bus_a.rsv_en = rsv_en_v;  bus_b.rsv_en = rsv_en_v;
    bus_a.rsv_addr = rsv_addr_v;  bus_b.rsv_addr = rsv_addr_v;
    for (int i = 0; i < NRD; i++) begin
      bus_a.rd_addr[i] = rd_addr_v[i];
      bus_b.rd_addr[i] = rd_addr_v[i];
    end
    for (int j = 0; j < NWR; j++) begin
      bus_a.wr_en[j] = wr_en_v[j];      bus_b.wr_en[j] = wr_en_v[j];
      bus_a.wr_addr[j] = wr_addr_v[j];  bus_b.wr_addr[j] = wr_addr_v[j];
      bus_a.wr_data[j] = wr_data_v[j];  bus_b.wr_data[j] = wr_data_v[j];
    end
    if (rst_v) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 32; r++) begin
          m_reg[k][r]  = '0;
          m_busy[k][r] = 1'b0;
        end
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NRD; i++) begin
        e.inst = k;
        e.port = i;
        e.cyc  = cyc;
        m_read(k, rd_addr_v[i], e.data, e.busy);
        exp_q.push_back(e);
      end
    end
    if (!rst_v) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en_v[j] && m_real(k, wr_addr_v[j])) begin
            m_reg[k][wr_addr_v[j]]  = wr_data_v[j];
            m_busy[k][wr_addr_v[j]] = 1'b0;
          end
        end
        if (rsv_en_v && m_real(k, rsv_addr_v)) m_busy[k][rsv_addr_v] = 1'b1;
      end
    end
  endtask

  task automatic wr(int port, int a, logic [31:0] d);
    wr_en_v[port]   = 1'b1;
    wr_addr_v[port] = AW'(a);
    wr_data_v[port] = d;
  endtask

  task automatic rd(int a0, int a1);
    rd_addr_v[0] = AW'(a0);
    rd_addr_v[1] = AW'(a1);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(1) != 0) ? AW'($urandom_range(7)) : AW'($urandom_range(31));
  endfunction

  // Monitor: outputs are valid every cycle; compare them mid-cycle against the queue.
  initial begin
    exp_t e;
    logic [31:0] ad;
    logic        ab;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ad = (e.inst == 0) ? bus_a.rd_data[e.port] : bus_b.rd_data[e.port];
        ab = (e.inst == 0) ? bus_a.rd_busy[e.port] : bus_b.rd_busy[e.port];
        total++;
        if (ad !== e.data) begin
          bad++;
          $display("FAIL rd_data inst%0d port%0d cyc%0d: got %h expected %h",
                   e.inst, e.port, e.cyc, ad, e.data);
        end
        total++;
        if (ab !== e.busy) begin
          bad++;
          $display("FAIL rd_busy inst%0d port%0d cyc%0d: got %b expected %b",
                   e.inst, e.port, e.cyc, ab, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_v = 1'b1;
    step();
    step();
    // Sequential writes then reads.
    idle(); wr(0, 1, 32'd1); rd(1, 2); step();
    idle(); wr(0, 2, 32'd2); rd(1, 2); step();
    idle(); wr(0, 3, 32'd3); rd(3, 0); step();
    idle(); rd(1, 2); step();
    idle(); rd(3, 0); step();
    // Two ports hit the same register: port 1 wins.
    idle(); wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(7, 7); step();
    idle(); rd(7, 1); step();
    // Same-cycle forwarding (instance A only).
    idle(); wr(0, 4, 32'h1234); rd(4, 3); step();
    idle(); rd(4, 4); step();
    // Reservation and busy clear.
    idle(); rsv_en_v = 1'b1; rsv_addr_v = 5'd9; rd(9, 9); step();
    idle(); rd(9, 1); step();
    idle(); wr(1, 9, 32'h77); rd(9, 9); step();
    idle(); rd(9, 9); step();
    idle(); wr(0, 9, 32'h88); rsv_en_v = 1'b1; rsv_addr_v = 5'd9; rd(9, 9); step();
    idle(); rd(9, 9); step();
    // x0 hardwired; out-of-range address on the 24-entry file.
    idle(); wr(0, 0, 32'hFFFF); rsv_en_v = 1'b1; rsv_addr_v = 5'd0; rd(0, 0); step();
    idle(); rd(0, 0); step();
    idle(); wr(1, 30, 32'h1111); rsv_en_v = 1'b1; rsv_addr_v = 5'd30; rd(30, 30); step();
    idle(); rd(30, 30); step();
    // Reset pulse mid-run clears data and busy.
    idle(); wr(0, 5, 32'hDEADBEEF); rd(5, 9); step();
    idle(); rd(5, 9); step();
    idle(); rst_v = 1'b1; wr(1, 5, 32'h5); rd(5, 9); step();
    idle(); rst_v = 1'b1; rd(5, 9); step();
    idle(); rd(5, 9); step();
    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst_v = ($urandom_range(63) == 0);
      for (int i = 0; i < NRD; i++) rd_addr_v[i] = rnd_addr();
      for (int j = 0; j < NWR; j++) begin
        wr_en_v[j]   = ($urandom_range(1) != 0);
        wr_addr_v[j] = rnd_addr();
        wr_data_v[j] = $urandom;
      end
      rsv_en_v   = ($urandom_range(3) == 0);
      rsv_addr_v = rnd_addr();
      step();
    end
    idle();
    repeat (3) @(negedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
